// File: rtl/write_combine_buffer.sv
`default_nettype none
// ============================================================================
// Module   : write_combine_buffer
// Purpose  : Posted-write queue with byte-merge between CPU port and bus master.
// Revision : 1.0 - initial release
// ============================================================================
module write_combine_buffer #(
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter bit STALL_READ    = 1'b0,
    parameter bit COMBINE       = 1'b1
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    input  logic                         i_cached,
    input  logic                         i_flush,
    output logic                         o_bus_rw,
    output logic                         o_bus_request,
    input  logic                         i_bus_ready,
    output logic [ADDRESS_WIDTH-1:0]     o_bus_address,
    input  logic [31:0]                  i_bus_rdata,
    output logic [31:0]                  o_bus_wdata,
    output logic [3:0]                   o_bus_wmask,
    input  logic                         i_rw,
    input  logic                         i_request,
    output logic                         o_ready,
    input  logic [ADDRESS_WIDTH-1:0]     i_address,
    output logic [31:0]                  o_rdata,
    input  logic [31:0]                  i_wdata,
    input  logic [3:0]                   i_wmask
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WA_W  = ADDRESS_WIDTH - 2;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UPSTREAM = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t            r_state;
    logic [DEPTH-1:0]  r_valid;
    logic [WA_W-1:0]   r_waddr [DEPTH];
    logic [31:0]       r_wdata [DEPTH];
    logic [3:0]        r_wmask [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;

    logic [WA_W-1:0]   w_word;
    logic [DEPTH-1:0]  w_match;
    logic [DEPTH-1:0]  w_merge_sel;
    logic [31:0]       w_merged      [DEPTH];
    logic [3:0]        w_merged_mask [DEPTH];
    logic              w_cached_wr;
    logic              w_merge;
    logic              w_push;
    logic              w_pop;
    logic              w_up_done;
    logic              w_read_ok;
    logic              w_up_go;
    logic [31:0]       w_head_wdata;
    logic [3:0]        w_head_wmask;
    logic [CNT_W-1:0]  w_count_next;

    assign w_word = i_address[ADDRESS_WIDTH-1:2];

    // The head entry is frozen once it is on the bus; merges must not touch it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
            assign w_match[gi]     = r_valid[gi] && (r_waddr[gi] == w_word);
            assign w_merge_sel[gi] = COMBINE && w_match[gi] &&
                                     !((r_state == ST_DRAIN) && (r_head == IDX));
            for (genvar gb = 0; gb < 4; gb++) begin : g_byte
                assign w_merged[gi][8*gb +: 8] = i_wmask[gb] ? i_wdata[8*gb +: 8]
                                                             : r_wdata[gi][8*gb +: 8];
            end
            assign w_merged_mask[gi] = r_wmask[gi] | i_wmask;
        end
    endgenerate

    assign w_cached_wr  = i_request && i_rw && i_cached && !i_flush;
    assign w_merge      = w_cached_wr && (|w_merge_sel);
    assign w_push       = w_cached_wr && !(|w_merge_sel) && !r_full;
    assign w_pop        = (r_state == ST_DRAIN) && i_bus_ready;
    assign w_up_done    = (r_state == ST_UPSTREAM) && i_bus_ready;
    assign w_read_ok    = STALL_READ ? r_empty : !(|w_match);
    assign w_up_go      = i_request && (i_rw ? (!i_cached && r_empty) : w_read_ok);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // A merge into the head in the cycle the drain starts must reach the bus.
    assign w_head_wdata = (w_merge && w_merge_sel[r_head]) ? w_merged[r_head]      : r_wdata[r_head];
    assign w_head_wmask = (w_merge && w_merge_sel[r_head]) ? w_merged_mask[r_head] : r_wmask[r_head];

    assign o_ready = w_up_done || w_merge || w_push;
    assign o_rdata = w_up_done ? i_bus_rdata : 32'd0;
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= '0;
                r_wdata[i] <= '0;
                r_wmask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_merge && w_merge_sel[i]) begin
                    r_wdata[i] <= w_merged[i];
                    r_wmask[i] <= w_merged_mask[i];
                end
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_waddr[r_tail] <= w_word;
                r_wdata[r_tail] <= i_wdata;
                r_wmask[r_tail] <= i_wmask;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == C_DEPTH);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_bus_wmask   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_up_go) begin
                        r_state       <= ST_UPSTREAM;
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= i_rw;
                        o_bus_address <= i_address;
                        o_bus_wdata   <= i_wdata;
                        o_bus_wmask   <= i_wmask;
                    end else if (!r_empty) begin
                        r_state       <= ST_DRAIN;
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= 1'b1;
                        o_bus_address <= {r_waddr[r_head], 2'b00};
                        o_bus_wdata   <= w_head_wdata;
                        o_bus_wmask   <= w_head_wmask;
                    end
                end
                ST_UPSTREAM, ST_DRAIN: begin
                    if (i_bus_ready) begin
                        r_state       <= ST_IDLE;
                        o_bus_request <= 1'b0;
                        o_bus_rw      <= 1'b0;
                        o_bus_address <= '0;
                        o_bus_wdata   <= '0;
                        o_bus_wmask   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_write_combine_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_combine_buffer
// Purpose  : Scoreboard bench for write_combine_buffer (DEPTH 4, STALL_READ 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_combine_buffer;
    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        o_empty, o_full;
    logic [2:0]  o_count;
    logic        i_cached, i_flush;
    logic        o_bus_rw, o_bus_request;
    logic        i_bus_ready;
    logic [31:0] o_bus_address, i_bus_rdata, o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic        i_rw, i_request, o_ready;
    logic [31:0] i_address, o_rdata, i_wdata;
    logic [3:0]  i_wmask;

    always #5 clk = ~clk;

    write_combine_buffer #(.DEPTH(4), .ADDRESS_WIDTH(32), .STALL_READ(1'b0), .COMBINE(1'b1)) dut (
        .i_clock(clk), .i_reset_n(i_reset_n), .o_empty(o_empty), .o_full(o_full),
        .o_count(o_count), .i_cached(i_cached), .i_flush(i_flush), .o_bus_rw(o_bus_rw),
        .o_bus_request(o_bus_request), .i_bus_ready(i_bus_ready), .o_bus_address(o_bus_address),
        .i_bus_rdata(i_bus_rdata), .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask),
        .i_rw(i_rw), .i_request(i_request), .o_ready(o_ready), .i_address(i_address),
        .o_rdata(o_rdata), .i_wdata(i_wdata), .i_wmask(i_wmask)
    );

    typedef struct { logic rw; logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } bus_t;
    typedef struct { logic is_read; logic via_bus; logic [31:0] addr; logic [31:0] rdata; } up_t;

    bus_t exp_bus[$];
    up_t  exp_up[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   slave_en = 1'b0;
    int   slave_lat = 1;
    int   pulse_req = 0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic record_fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Bus slave: pulses ready after slave_lat cycles, or once per pulse_req.
    initial begin
        int wait_cnt = 0;
        int pulse_done = 0;
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (i_bus_ready) begin
                i_bus_ready = 1'b0;
                i_bus_rdata = 32'd0;
                wait_cnt    = 0;
            end else if (o_bus_request) begin
                if (pulse_req > pulse_done) begin
                    i_bus_ready = 1'b1;
                    i_bus_rdata = rd_model(o_bus_address);
                    pulse_done++;
                end else if (slave_en) begin
                    if (wait_cnt >= slave_lat) begin
                        i_bus_ready = 1'b1;
                        i_bus_rdata = rd_model(o_bus_address);
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (i_reset_n && o_bus_request && i_bus_ready) begin
                if (exp_bus.size() == 0) begin
                    record_fail("bus_unexpected", $sformatf("addr 0x%0h rw %0d", o_bus_address, o_bus_rw));
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_rw", o_bus_rw, e.rw);
                    check("bus_addr", o_bus_address, e.addr);
                    if (e.rw) begin
                        check("bus_wdata", o_bus_wdata, e.data);
                        check("bus_wmask", o_bus_wmask, e.mask);
                    end
                end
            end
        end
    end

    initial begin
        up_t u;
        forever begin
            @(negedge clk);
            if (i_reset_n && o_ready) begin
                if (exp_up.size() == 0) begin
                    record_fail("ready_unexpected", $sformatf("addr 0x%0h", i_address));
                end else begin
                    u = exp_up.pop_front();
                    check("up_addr", i_address, u.addr);
                    if (u.via_bus) begin
                        check("up_own_bus_ready", i_bus_ready, 1);
                        check("up_bus_addr", o_bus_address, u.addr);
                    end
                    if (u.is_read) check("up_rdata", o_rdata, u.rdata);
                end
            end
        end
    end

    task automatic drive(input logic rw, input logic cached, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        i_rw = rw; i_cached = cached; i_address = a; i_wdata = d; i_wmask = m;
        i_request = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n = 0;
        forever begin
            @(negedge clk);
            if (o_ready) break;
            n++;
            if (n >= limit) begin
                record_fail(name, "timeout waiting for o_ready");
                break;
            end
        end
        @(posedge clk); #1;
        i_request = 1'b0;
    endtask

    task automatic expect_bus(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        exp_bus.push_back('{rw, a, d, m});
    endtask

    task automatic expect_up(input logic is_read, input logic via_bus, input logic [31:0] a);
        exp_up.push_back('{is_read, via_bus, a, rd_model(a)});
    endtask

    task automatic cwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        expect_up(1'b0, 1'b0, a);
        drive(1'b1, 1'b1, a, d, m);
        wait_ready("cached_write", 20);
    endtask

    task automatic wait_empty(input string name, input int limit);
        int n = 0;
        while (!(o_empty && !o_bus_request)) begin
            @(negedge clk);
            n++;
            if (n > limit) begin
                record_fail(name, "timeout waiting for empty queue");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit flag;
        int n;
        i_reset_n = 1'b0; i_cached = 1'b0; i_flush = 1'b0; i_rw = 1'b0; i_request = 1'b0;
        i_address = '0; i_wdata = '0; i_wmask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_count", o_count, 0);
        check("rst_bus_req", o_bus_request, 0);
        check("rst_bus_addr", o_bus_address, 0);
        check("rst_ready", o_ready, 0);
        check("rst_rdata", o_rdata, 0);
        @(posedge clk); #1;
        i_reset_n = 1'b1;
        @(posedge clk); #1;

        // Combine: two partial writes to one word become one bus write
        slave_en = 1'b0;
        expect_bus(1'b1, 32'h100, 32'h0022_0011, 4'b0101);
        cwrite(32'h100, 32'h0000_0011, 4'b0001);
        cwrite(32'h100, 32'h0022_0000, 4'b0100);
        @(negedge clk);
        check("comb_count", o_count, 1);
        check("comb_req", o_bus_request, 1);
        check("comb_wdata", o_bus_wdata, 32'h0022_0011);
        check("comb_wmask", o_bus_wmask, 4'b0101);
        pulse_req++;
        wait_empty("comb_drain", 20);

        // Full: fifth write stalls until the first pop
        for (int i = 0; i < 5; i++) expect_bus(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) cwrite(32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        @(negedge clk);
        check("full_flag", o_full, 1);
        check("full_count", o_count, 4);
        @(posedge clk); #1;
        expect_up(1'b0, 1'b0, 32'h10);
        drive(1'b1, 1'b1, 32'h10, 32'hA4, 4'hF);
        flag = 1'b1;
        repeat (3) begin @(negedge clk); if (o_ready) flag = 1'b0; end
        check("full_stall", flag, 1);
        pulse_req++;
        @(negedge clk);
        check("full_no_same_cycle_slot", o_ready, 0);
        wait_ready("full_fifth", 10);
        slave_en = 1'b1;
        wait_empty("full_drain", 100);

        // Hazard: a non-matching read overtakes queued writes
        slave_en = 1'b0;
        expect_bus(1'b1, 32'h20, 32'h2020, 4'hF);
        expect_bus(1'b0, 32'h40, 32'h0, 4'h0);
        expect_bus(1'b1, 32'h24, 32'h2424, 4'hF);
        cwrite(32'h20, 32'h2020, 4'hF);
        cwrite(32'h24, 32'h2424, 4'hF);
        expect_up(1'b1, 1'b1, 32'h40);
        drive(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
        slave_en = 1'b1;
        wait_ready("hazard_read_miss", 50);
        wait_empty("hazard_drain", 100);

        // Hazard: a matching read waits for the write to leave the queue
        slave_en = 1'b0;
        expect_bus(1'b1, 32'h24, 32'h2424_2424, 4'hF);
        expect_bus(1'b0, 32'h24, 32'h0, 4'h0);
        cwrite(32'h24, 32'h2424_2424, 4'hF);
        expect_up(1'b1, 1'b1, 32'h24);
        drive(1'b0, 1'b1, 32'h24, 32'h0, 4'h0);
        flag = 1'b1;
        repeat (4) begin @(negedge clk); if (o_ready || (o_bus_request && !o_bus_rw)) flag = 1'b0; end
        check("hazard_hit_wait", flag, 1);
        slave_en = 1'b1;
        wait_ready("hazard_read_hit", 50);
        wait_empty("hazard_hit_drain", 100);

        // Uncached write waits behind queued writes
        slave_en = 1'b0;
        expect_bus(1'b1, 32'h0, 32'h1111_0000, 4'hF);
        expect_bus(1'b1, 32'h4, 32'h2222_0000, 4'hF);
        expect_bus(1'b1, 32'h80, 32'hDEAD_BEEF, 4'b0011);
        cwrite(32'h0, 32'h1111_0000, 4'hF);
        cwrite(32'h4, 32'h2222_0000, 4'hF);
        expect_up(1'b0, 1'b1, 32'h80);
        drive(1'b1, 1'b0, 32'h80, 32'hDEAD_BEEF, 4'b0011);
        flag = 1'b1;
        repeat (3) begin @(negedge clk); if (o_ready) flag = 1'b0; end
        check("uncached_stall", flag, 1);
        slave_en = 1'b1;
        wait_ready("uncached_done", 60);
        wait_empty("uncached_drain", 100);

        // Flush blocks cached writes while the queue drains
        slave_en = 1'b0;
        for (int i = 0; i < 4; i++) expect_bus(1'b1, 32'h200 + 32'(i * 4), 32'h5000 + 32'(i), 4'hF);
        for (int i = 0; i < 3; i++) cwrite(32'h200 + 32'(i * 4), 32'h5000 + 32'(i), 4'hF);
        i_flush = 1'b1;
        expect_up(1'b0, 1'b0, 32'h20C);
        drive(1'b1, 1'b1, 32'h20C, 32'h5003, 4'hF);
        flag = 1'b1;
        repeat (3) begin @(negedge clk); if (o_ready) flag = 1'b0; end
        check("flush_stall", flag, 1);
        slave_en = 1'b1;
        n = 0;
        while (!o_empty && n < 100) begin
            @(negedge clk);
            if (o_ready) flag = 1'b0;
            n++;
        end
        check("flush_reached_empty", o_empty, 1);
        check("flush_held_write", flag, 1);
        @(posedge clk); #1;
        i_flush = 1'b0;
        wait_ready("flush_release", 10);
        wait_empty("flush_drain", 100);

        // Asynchronous reset in the middle of a drain
        slave_en = 1'b0;
        cwrite(32'h300, 32'h3000, 4'hF);
        cwrite(32'h304, 32'h3004, 4'hF);
        @(negedge clk);
        check("rst_mid_req_before", o_bus_request, 1);
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_mid_req", o_bus_request, 0);
        check("rst_mid_count", o_count, 0);
        check("rst_mid_empty", o_empty, 1);
        @(posedge clk); #1;
        i_reset_n = 1'b1;
        slave_en = 1'b1;
        flag = 1'b0;
        repeat (10) begin @(negedge clk); if (o_bus_request) flag = 1'b1; end
        check("rst_no_stale", flag, 0);

        check("bus_queue_left", exp_bus.size(), 0);
        check("ready_queue_left", exp_up.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
